// File: rtl/icache_dm_if.sv
// Fetch-side and backing-memory-side signal bundle for the direct-mapped instruction cache.
// The slave modport is the cache's view; the master modport is the core/memory environment's view.
interface icache_dm_if #(
    parameter int ADDR_W = 32
) ();
    logic              core_req_i;
    logic [ADDR_W-1:2] core_addr_i;
    logic [31:0]       core_data_o;
    logic              core_stall_o;
    logic              flush_i;
    logic              mem_req_o;
    logic [ADDR_W-1:2] mem_addr_o;
    logic              mem_ack_i;
    logic [31:0]       mem_data_i;

    modport slave (
        input  core_req_i, core_addr_i, flush_i, mem_ack_i, mem_data_i,
        output core_data_o, core_stall_o, mem_req_o, mem_addr_o
    );

    modport master (
        output core_req_i, core_addr_i, flush_i, mem_ack_i, mem_data_i,
        input  core_data_o, core_stall_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hit lookup, in-order whole-line refill over a
// word-wide req/ack memory port, and whole-cache invalidation.
module icache_dm #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    icache_dm_if.slave  bus
);
    localparam int WA_W  = ADDR_W - 2;
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WA_W - OFF_W - IDX_W;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REFILL = 1'b1;

    logic [0:0]       state_r;
    logic [OFF_W-1:0] cnt_r;
    logic [WA_W-1:0]  base_r;
    logic             mem_req_r;
    logic [WA_W-1:0]  mem_addr_r;
    logic [SETS-1:0]  valid_r;
    logic [TAG_W-1:0] tag_mem [SETS];
    logic [31:0]      data_mem [SETS*LINE_WORDS];

    logic [OFF_W-1:0] off_s;
    logic [IDX_W-1:0] idx_s;
    logic [TAG_W-1:0] tag_s;
    logic [IDX_W-1:0] ref_idx_s;
    logic [TAG_W-1:0] ref_tag_s;
    logic             hit_s;
    logic             start_s;
    logic             word_done_s;
    logic             fill_done_s;
    logic [SETS-1:0]  set_mask_s;
    logic [SETS-1:0]  valid_nxt_s;

    assign off_s     = bus.core_addr_i[OFF_W+1:2];
    assign idx_s     = bus.core_addr_i[OFF_W+IDX_W+1:OFF_W+2];
    assign tag_s     = bus.core_addr_i[ADDR_W-1:OFF_W+IDX_W+2];
    assign ref_idx_s = base_r[OFF_W+IDX_W-1:OFF_W];
    assign ref_tag_s = base_r[WA_W-1:OFF_W+IDX_W];

    assign hit_s       = valid_r[idx_s] && (tag_mem[idx_s] == tag_s);
    assign start_s     = (state_r == ST_IDLE) && bus.core_req_i && !hit_s;
    assign word_done_s = (state_r == ST_REFILL) && bus.mem_ack_i;
    assign fill_done_s = word_done_s && (cnt_r == OFF_W'(LINE_WORDS - 1));

    // A flush wipes prior contents but never the line whose final word lands on the same edge.
    assign set_mask_s  = fill_done_s ? ({{(SETS-1){1'b0}}, 1'b1} << ref_idx_s) : {SETS{1'b0}};
    assign valid_nxt_s = (bus.flush_i ? {SETS{1'b0}} : valid_r) | set_mask_s;

    assign bus.core_data_o  = data_mem[{idx_s, off_s}];
    assign bus.core_stall_o = bus.core_req_i && ((state_r != ST_IDLE) || !hit_s);
    assign bus.mem_req_o    = mem_req_r;
    assign bus.mem_addr_o   = mem_addr_r;

    // Refill sequencer: line base latch, word counter, memory request and valid bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {OFF_W{1'b0}};
            base_r     <= {WA_W{1'b0}};
            mem_req_r  <= 1'b0;
            mem_addr_r <= {WA_W{1'b0}};
            valid_r    <= {SETS{1'b0}};
        end else begin
            valid_r <= valid_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r    <= ST_REFILL;
                        cnt_r      <= {OFF_W{1'b0}};
                        base_r     <= {bus.core_addr_i[ADDR_W-1:OFF_W+2], {OFF_W{1'b0}}};
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= {bus.core_addr_i[ADDR_W-1:OFF_W+2], {OFF_W{1'b0}}};
                    end else begin
                        mem_req_r  <= 1'b0;
                        mem_addr_r <= {WA_W{1'b0}};
                    end
                end
                ST_REFILL: begin
                    if (fill_done_s) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= {OFF_W{1'b0}};
                        mem_req_r  <= 1'b0;
                        mem_addr_r <= {WA_W{1'b0}};
                    end else if (word_done_s) begin
                        cnt_r      <= cnt_r + 1'b1;
                        mem_addr_r <= {base_r[WA_W-1:OFF_W], cnt_r + 1'b1};
                    end else begin
                        cnt_r      <= cnt_r;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= {OFF_W{1'b0}};
                    mem_req_r  <= 1'b0;
                    mem_addr_r <= {WA_W{1'b0}};
                end
            endcase
        end
    end

    // Data and tag arrays carry no reset; only valid bits qualify their contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i && word_done_s) begin
            data_mem[{ref_idx_s, cnt_r}] <= bus.mem_data_i;
            if (fill_done_s) begin
                tag_mem[ref_idx_s] <= ref_tag_s;
            end
        end
    end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
Parametrised direct-mapped instruction cache for the RISC-V core fetch path. Replaces the fixed combinational instruction store.
- Hit: returns the instruction word in the same cycle as the lookup.
- Miss: stalls the core and refills a whole line from a word-wide backing memory through a req/ack handshake.
- Supports whole-cache invalidation (fence.i / program reload).

Parameters:
ADDR_W, 32, byte-address width; all word-address ports are ADDR_W-2 bits ([ADDR_W-1:2]).
LINE_WORDS, 4, 32-bit words per line; power of two, >=2.
SETS, 64, number of lines; power of two, >=2.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  synchronous, active-high reset.
core_req_i  in  1  fetch request valid.
core_addr_i  in  ADDR_W-2  fetch word address.
core_data_o  out  32  instruction word; valid when core_req_i=1 and core_stall_o=0.
core_stall_o  out  1  core must hold core_addr_i and stall.
flush_i  in  1  invalidate all lines (single-cycle pulse).
mem_req_o  out  1  backing-memory word read request.
mem_addr_o  out  ADDR_W-2  backing-memory word address.
mem_ack_i  in  1  mem_data_i valid; completes current request.
mem_data_i  in  32  backing-memory read data.

Behaviour:
- Address split of core_addr_i, from LSB upward:
  - offset: log2(LINE_WORDS) bits.
  - index: log2(SETS) bits.
  - tag: the remaining bits.
- Storage:
  - data array SETS x LINE_WORDS x 32.
  - tag array SETS x tag width.
  - valid bit per set.
  - Arrays need no reset; valid bits do.
- hit = valid[index] & (tag_array[index] == tag). Combinational, same cycle.
- core_data_o = data[index][offset] (combinational). Don't-care when not a hit.
- core_stall_o = core_req_i & (state != IDLE | ~hit).
- core_req_i=0 never stalls and never starts a refill.
- FSM states: IDLE and REFILL.
  - IDLE -> REFILL when core_req_i & ~hit. On that edge:
    - latch the line base (core_addr_i with offset zeroed) and index;
    - clear word counter cnt;
    - assert mem_req_o.
  - In REFILL:
    - mem_req_o=1 and mem_addr_o = line_base + cnt.
    - Hold both stable until mem_ack_i.
    - On a mem_ack_i edge: write mem_data_i into data[index][cnt]; cnt++.
    - Next request follows immediately. No idle cycle between words when mem_ack_i is held high.
  - On the ack for cnt = LINE_WORDS-1: write the tag, set valid[index]=1, deassert mem_req_o, return to IDLE.
  - The next cycle's lookup hits.
  - Miss penalty with single-cycle-ack memory: LINE_WORDS+1 stall cycles.
- Words are always fetched in order 0..LINE_WORDS-1 (no critical-word-first).
- mem_req_o=0 and mem_addr_o=0 in IDLE.
- flush_i:
  - Clears all valid bits on that edge, in either state.
  - If asserted during REFILL, the refill still completes and its line is installed valid. The flush applies only to prior contents.
  - If flush_i coincides with the final ack, the refilled line ends valid and all others invalid.
- Core protocol: core_addr_i must be held stable while core_stall_o=1. If it changes, the in-flight refill still completes for the latched line.
- Reset (any time, including mid-refill), on the next edge:
  - state=IDLE, cnt=0, all valid bits=0;
  - mem_req_o=0, mem_addr_o=0.
  - A pending memory transaction is abandoned. The memory model must tolerate this.
- Outputs after reset: core_stall_o = core_req_i (everything misses); core_data_o don't-care.

Test Plan:
Defaults are used. The memory model returns data = byte address and acks 1 cycle after req unless stated.
1. Cold miss: req addr byte 0x100 (word 0x40) -> stall; mem_addr_o 0x40,0x41,0x42,0x43; stall drops after 5 cycles; core_data_o=0x00000100.
2. Same-line hit: after test 1, byte 0x108 -> no stall, same cycle core_data_o=0x00000108, mem_req_o stays 0.
3. Conflict eviction: byte 0x500 (index 16, tag 1) -> miss, refill 0x140..0x143, data 0x00000500. Then byte 0x100 -> miss again.
4. Slow memory: ack delayed 3 cycles per word -> mem_addr_o held stable until each ack; total stall 4*4+1=17 cycles; correct data.
5. Flush: after a 0x100 hit, pulse flush_i -> next 0x100 misses. Flush mid-refill -> the refilling line hits afterwards.
6. Reset mid-refill: assert rst_i after 2nd ack -> next cycle mem_req_o=0; a 0x100 request misses and refills fully.
